// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic PE blocks: bit-serial adder FSM encodings and limits.
package systolic_pkg;

    localparam logic [1:0] BSA_IDLE = 2'd0;
    localparam logic [1:0] BSA_RUN  = 2'd1;
    localparam logic [1:0] BSA_DONE = 2'd2;

    localparam int unsigned BSA_WIDTH_MAX = 32;

endpackage

// File: rtl/fulladd.sv
// Single-bit full adder cell; the only arithmetic element of the bit-serial adder.
module fulladd (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/bit_serial_add_ctrl.sv
// Word-level add over one fulladd cell, LSB first, with valid/ready on both sides.
// Optional subtract mode (sub_i port) is enabled by defining BSA_SUBTRACT_EN.
module bit_serial_add_ctrl
    import systolic_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    input  logic             c_in_i,
`ifdef BSA_SUBTRACT_EN
    input  logic             sub_i,
`endif
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             c_out_o,
    output logic             busy_o
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             c_out_q, c_out_d;
    logic             fa_sum, fa_carry;

    fulladd u_fulladd (
        .a_i (a_sr_q[0]),
        .b_i (b_sr_q[0]),
        .c_i (carry_q),
        .s_o (fa_sum),
        .c_o (fa_carry)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        result_d = result_q;
        carry_d  = carry_q;
        c_out_d  = c_out_q;
        case (state_q)
            BSA_IDLE: begin
                // Operands are only looked at here, so X on idle inputs never reaches state.
                if (in_valid_i) begin
                    state_d  = BSA_RUN;
                    cnt_d    = '0;
                    a_sr_d   = op_a_i;
                    result_d = '0;
`ifdef BSA_SUBTRACT_EN
                    b_sr_d   = sub_i ? ~op_b_i : op_b_i;
                    carry_d  = sub_i | c_in_i;
`else
                    b_sr_d   = op_b_i;
                    carry_d  = c_in_i;
`endif
                end
            end
            BSA_RUN: begin
                result_d = {fa_sum, result_q[WIDTH-1:1]};
                a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
                carry_d  = fa_carry;
                if (cnt_q == CntLast) begin
                    state_d = BSA_DONE;
                    c_out_d = fa_carry;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            BSA_DONE: begin
                if (out_ready_i) state_d = BSA_IDLE;
            end
            default: state_d = BSA_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= BSA_IDLE;
            cnt_q    <= '0;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            c_out_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            c_out_q  <= c_out_d;
        end
    end

    assign in_ready_o  = (state_q == BSA_IDLE);
    assign out_valid_o = (state_q == BSA_DONE);
    assign busy_o      = (state_q == BSA_RUN) || (state_q == BSA_DONE);
    assign result_o    = result_q;
    assign c_out_o     = c_out_q;

endmodule

// File: tb/tb_bit_serial_add_ctrl.sv
// Self-checking bench for bit_serial_add_ctrl: vector table, corner sequences, random vs. model.
module tb_bit_serial_add_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         c_in;
`ifdef BSA_SUBTRACT_EN
    logic         sub;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         c_out;
    logic         busy;

    int total = 0;
    int bad   = 0;

    bit_serial_add_ctrl #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .op_a_i      (op_a),
        .op_b_i      (op_b),
        .c_in_i      (c_in),
`ifdef BSA_SUBTRACT_EN
        .sub_i       (sub),
`endif
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .result_o    (result),
        .c_out_o     (c_out),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] exp_res;
        logic         exp_cout;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sb);
        longint ai, bi, s;
        ai = longint'(a);
        bi = longint'(b);
        if (sb) begin
            s = ai - bi;
            return {(ai >= bi), s[W-1:0]};
        end
        s = ai + bi + longint'(cin);
        return s[W:0];
    endfunction

    // Entered and left at #1 after a rising edge.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic sb, input int hold,
                          output logic [W-1:0] res, output logic co, output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        op_a = a;
        op_b = b;
        c_in = cin;
`ifdef BSA_SUBTRACT_EN
        sub = sb;
`else
        if (sb) $display("note: subtract requested without BSA_SUBTRACT_EN");
`endif
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        op_a = 'x;
        op_b = 'x;
        c_in = ~cin;
        lat = 0;
        while (!out_valid && lat < 4 * W) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) chk("out_valid_timeout", 64'(out_valid), 64'd1);
        res = result;
        co  = c_out;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_result", 64'(result), 64'(res));
            chk("hold_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("post_hs_in_ready", 64'(in_ready), 64'd1);
        chk("post_hs_out_valid", 64'(out_valid), 64'd0);
    endtask

    initial begin
        vec_t         vecs[6];
        logic [W-1:0] r, r0, r1;
        logic         co, co0, co1;
        logic [W:0]   e;
        logic         sb;
        int           lat, k, acc1, acc2, got, stray;

        vecs[0] = '{a: 8'h5A, b: 8'h33, cin: 1'b0, exp_res: 8'h8D, exp_cout: 1'b0};
        vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b1, exp_res: 8'h01, exp_cout: 1'b1};
        vecs[2] = '{a: 8'h00, b: 8'h00, cin: 1'b0, exp_res: 8'h00, exp_cout: 1'b0};
        vecs[3] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, exp_res: 8'hFF, exp_cout: 1'b1};
        vecs[4] = '{a: 8'h80, b: 8'h80, cin: 1'b0, exp_res: 8'h00, exp_cout: 1'b1};
        vecs[5] = '{a: 8'h01, b: 8'h01, cin: 1'b0, exp_res: 8'h02, exp_cout: 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; op_a = '0; op_b = '0; c_in = 1'b0; out_ready = 1'b0;
`ifdef BSA_SUBTRACT_EN
        sub = 1'b0;
`endif
        #2;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_c_out", 64'(c_out), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, 0, r, co, lat);
            chk("vec_result", 64'(r), 64'(vecs[i].exp_res));
            chk("vec_c_out", 64'(co), 64'(vecs[i].exp_cout));
            chk("vec_latency", 64'(lat), 64'(W));
        end

        // Backpressure: result held, new operands ignored while in DONE.
        out_ready = 1'b0;
        op_a = 8'h5A; op_b = 8'h33; c_in = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        op_a = 8'h11; op_b = 8'h22;
        k = 0;
        while (!out_valid && k < 4 * W) begin
            @(posedge clk); #1;
            k++;
        end
        chk("bp_latency", 64'(k), 64'(W));
        r = result;
        co = c_out;
        chk("bp_result", 64'(r), 64'h8D);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_stable_result", 64'(result), 64'(r));
            chk("bp_stable_c_out", 64'(c_out), 64'(co));
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_release_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        chk("bp_nothing_accepted", 64'(busy), 64'd0);

        // Asynchronous reset after the 3rd RUN edge.
        op_a = 8'hFF; op_b = 8'hFF; c_in = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_result", 64'(result), 64'd0);
        chk("arst_c_out", 64'(c_out), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("arst_release_in_ready", 64'(in_ready), 64'd1);
        stray = 0;
        for (int i = 0; i < 2 * W; i++) begin
            if (out_valid || busy) stray++;
            @(posedge clk); #1;
        end
        chk("arst_no_stray", 64'(stray), 64'd0);

        // Back-to-back with in_valid held high across the output handshake.
        op_a = 8'h01; op_b = 8'h01; c_in = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        k = 0; acc1 = -1; acc2 = -1; got = 0;
        r0 = '0; r1 = '0; co0 = 1'b0; co1 = 1'b0;
        while (k < 60 && got < 2) begin
            if (in_ready && in_valid) begin
                if (acc1 < 0) acc1 = k;
                else if (acc2 < 0) acc2 = k;
            end
            @(posedge clk); #1;
            k++;
            if (acc2 >= 0) in_valid = 1'b0;
            else if (acc1 >= 0) begin
                op_a = 8'h80; op_b = 8'h80;
            end
            if (out_valid) begin
                if (got == 0) begin r0 = result; co0 = c_out; end
                else begin r1 = result; co1 = c_out; end
                got++;
            end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("b2b_count", 64'(got), 64'd2);
        chk("b2b_interval", 64'(acc2 - acc1), 64'(W + 2));
        chk("b2b_result0", 64'(r0), 64'h02);
        chk("b2b_c_out0", 64'(co0), 64'd0);
        chk("b2b_result1", 64'(r1), 64'h00);
        chk("b2b_c_out1", 64'(co1), 64'd1);
        chk("b2b_idle", 64'(in_ready), 64'd1);

`ifdef BSA_SUBTRACT_EN
        run_op(8'h10, 8'h01, 1'b0, 1'b1, 1, r, co, lat);
        chk("sub_result0", 64'(r), 64'h0F);
        chk("sub_c_out0", 64'(co), 64'd1);
        run_op(8'h01, 8'h02, 1'b1, 1'b1, 0, r, co, lat);
        chk("sub_result1", 64'(r), 64'hFF);
        chk("sub_c_out1", 64'(co), 64'd0);
`endif

        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra, rb;
            logic         rc;
            int           hold;
            ra   = W'($urandom);
            rb   = W'($urandom);
            rc   = 1'($urandom_range(0, 1));
            hold = int'($urandom_range(0, 3));
`ifdef BSA_SUBTRACT_EN
            sb = 1'($urandom_range(0, 1));
`else
            sb = 1'b0;
`endif
            e = model(ra, rb, rc, sb);
            run_op(ra, rb, rc, sb, hold, r, co, lat);
            chk("rand_result", 64'(r), 64'(e[W-1:0]));
            chk("rand_c_out", 64'(co), 64'(e[W]));
            chk("rand_latency", 64'(lat), 64'(W));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
